// File: rtl/monopix_ro_pkg.sv
// Shared types for the Monopix readout scheduler: hit word layout, flavours, FSM states.
// Also holds the round-robin pick used when granting a flavour.
package monopix_ro_pkg;

    localparam int SER_BITS = 27;

    typedef struct packed {
        logic [5:0] col;
        logic [5:0] te;
        logic [5:0] le;
        logic [8:0] row;
    } t_data;

    typedef enum logic [1:0] {
        FL_PMOS_NOSF = 2'd0,
        FL_PMOS      = 2'd1,
        FL_COMP      = 2'd2,
        FL_HV        = 2'd3
    } t_flavour;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREEZE = 3'd1,
        ST_READ   = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_STALL  = 3'd4
    } t_state;

    // Search starts one past the last grant and wraps 3->0; the last hit in the
    // descending loop is the nearest requester.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ro_gray_dec.sv
// 6-bit Gray-to-binary converter, purely combinational.
// Used for the le/te timestamp fields when RO_GRAY_DECODE_EN is defined.
module ro_gray_dec (
    input  logic [5:0] gray,
    output logic [5:0] bin
);

    always_comb begin
        bin[5] = gray[5];
        for (int i = 4; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/monopix_ro_sched.sv
// Readout scheduler: grants one pixel flavour at a time, sequences freeze/read, shifts in one hit word.
// Optional RO_GRAY_DECODE_EN converts le/te from Gray to binary on the way into the output register.
//
// state     | meaning
// ST_IDLE   | waiting for an enabled token, round-robin grant
// ST_FREEZE | freeze[sel] held TOKEN_WAIT_CYC cycles, aborts on token drop
// ST_READ   | read[sel] held READ_CYC cycles
// ST_SHIFT  | SER_BITS serial samples, then write or stall
// ST_STALL  | word complete, waiting for output register to free
module monopix_ro_sched
    import monopix_ro_pkg::*;
#(
    parameter int TOKEN_WAIT_CYC = 8,
    parameter int READ_CYC       = 4,
    parameter int SER_BITS       = monopix_ro_pkg::SER_BITS
) (
    input  logic                clk_out,
    input  logic                rst_n,
    input  logic [3:0]          enable,
    input  logic [3:0]          token,
    input  logic [3:0]          data_in,
    output logic [3:0]          read,
    output logic [3:0]          freeze,
    output logic [SER_BITS+1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready
);

    localparam logic [7:0] TW_LAST = 8'(TOKEN_WAIT_CYC - 1);
    localparam logic [7:0] RC_LAST = 8'(READ_CYC - 1);
    localparam logic [7:0] SB_DONE = 8'(SER_BITS);

    t_state              state, state_nxt;
    logic [1:0]          sel, sel_nxt;
    logic [7:0]          phase;
    logic [SER_BITS-1:0] shreg;
    logic                load;
    logic                out_free;
    t_data               word, word_dec;

    assign out_free = !data_valid || data_ready;
    assign word     = t_data'(shreg);

`ifdef RO_GRAY_DECODE_EN
    logic [5:0] le_bin, te_bin;

    ro_gray_dec u_dec_le (.gray(word.le), .bin(le_bin));
    ro_gray_dec u_dec_te (.gray(word.te), .bin(te_bin));

    always_comb begin
        word_dec    = word;
        word_dec.le = le_bin;
        word_dec.te = te_bin;
    end
`else
    assign word_dec = word;
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|(token & enable)) begin
                    sel_nxt   = rr_pick(token & enable, sel);
                    state_nxt = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                // A lost token while frozen means the hit went away; drop the frame.
                if (!token[sel])           state_nxt = ST_IDLE;
                else if (phase == TW_LAST) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (phase == RC_LAST) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (phase == SB_DONE) begin
                    if (out_free) begin
                        load      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (out_free) begin
                    load      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= 2'd3;
            phase      <= '0;
            shreg      <= '0;
            read       <= '0;
            freeze     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;

            if (state_nxt != state)  phase <= '0;
            else if (phase != 8'hFF) phase <= phase + 8'd1;

            if (state == ST_SHIFT && phase != SB_DONE) begin
                shreg <= {shreg[SER_BITS-2:0], data_in[sel]};
            end

            freeze <= (state_nxt != ST_IDLE) ? (4'b0001 << sel_nxt) : 4'b0000;
            read   <= (state_nxt == ST_READ) ? (4'b0001 << sel_nxt) : 4'b0000;

            if (load) begin
                data_out   <= {sel, word_dec};
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
